// File: rtl/aftab_arb_pkg.sv
// Shared types for the AFTAB memory arbiter: FSM states, owner encodings,
// default timeout, and a helper that sizes the timeout counter.
package aftab_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  localparam int DEFAULT_TIMEOUT = 255;

  // A limit of 0 means "no timeout"; keep at least one bit so the counter still elaborates.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/aftab_arb_timeout_counter.sv
// Clearable saturating cycle counter that flags when it has reached LIMIT.
// A LIMIT of 0 disables the expiry flag entirely.
module aftab_arb_timeout_counter
  import aftab_arb_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic incr,
  output logic expired
);

  localparam int WIDTH = cnt_width(LIMIT);
  localparam logic [WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [WIDTH-1:0] LIMIT_VAL = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr && (count_q != MAX_COUNT)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (LIMIT != 0) && (count_q == LIMIT_VAL);

endmodule

// File: rtl/aftab_mem_arbiter.sv
// Two-master round-robin arbiter in front of the byte-wide memory controller:
// the core (m0) and DMA/debug (m1) share one port through IDLE/BUSY/RELEASE.
module aftab_mem_arbiter
  import aftab_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0Read,
  input  logic              m0Write,
  input  logic [ADDR_W-1:0] m0Addr,
  input  logic [DATA_W-1:0] m0DataOut,
  output logic [DATA_W-1:0] m0DataIn,
  output logic              m0Ready,
  output logic              m0Error,

  input  logic              m1Read,
  input  logic              m1Write,
  input  logic [ADDR_W-1:0] m1Addr,
  input  logic [DATA_W-1:0] m1DataOut,
  output logic [DATA_W-1:0] m1DataIn,
  output logic              m1Ready,
  output logic              m1Error,

  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataOut,
  input  logic [DATA_W-1:0] memDataIn,
  input  logic              memReady,

  output logic [1:0]        grant
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     rr_ptr_q, rr_ptr_d;

  logic              m0_req;
  logic              m1_req;
  logic              busy;
  logic              expired;
  logic              own_rd;
  logic              own_wr;
  logic              own_req;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  assign m0_req  = m0Read | m0Write;
  assign m1_req  = m1Read | m1Write;
  assign busy    = (state_q == ST_BUSY);

  assign m0DataIn = memDataIn;
  assign m1DataIn = memDataIn;

  always_comb begin
    own_rd    = m0Read;
    own_wr    = m0Write;
    own_addr  = m0Addr;
    own_wdata = m0DataOut;
    if (owner_q == OWNER_M1) begin
      own_rd    = m1Read;
      own_wr    = m1Write;
      own_addr  = m1Addr;
      own_wdata = m1DataOut;
    end
  end

  assign own_req = own_rd | own_wr;

  // Counts BUSY cycles without memReady; held at zero outside BUSY so every transfer starts fresh.
  aftab_arb_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .incr    (busy && !memReady),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    memAddr    = '0;
    memDataOut = '0;
    grant      = 2'b00;
    m0Ready    = 1'b0;
    m1Ready    = 1'b0;
    m0Error    = 1'b0;
    m1Error    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) begin
            owner_d = rr_ptr_q;
          end else if (m1_req) begin
            owner_d = OWNER_M1;
          end else begin
            owner_d = OWNER_M0;
          end
          rr_ptr_d = (owner_d == OWNER_M0) ? OWNER_M1 : OWNER_M0;
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        memWrite   = own_wr;
        memRead    = own_rd & ~own_wr;
        memAddr    = own_addr;
        memDataOut = own_wdata;
        grant      = (owner_q == OWNER_M1) ? 2'b10 : 2'b01;
        m0Ready    = memReady & (owner_q == OWNER_M0);
        m1Ready    = memReady & (owner_q == OWNER_M1);

        // Completion beats abort, and abort beats a timeout landing on the same cycle.
        if (memReady || !own_req) begin
          state_d = ST_RELEASE;
        end else if (expired) begin
          state_d = ST_RELEASE;
          m0Error = (owner_q == OWNER_M0);
          m1Error = (owner_q == OWNER_M1);
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_M0;
      rr_ptr_q <= OWNER_M0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: doc/aftab_mem_arbiter.md
AFTAB_MEM_ARBITER -- requirements
Module: aftab_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 8, byte-wide data bus width.
REQ-003 Parameter TIMEOUT, default 255, maximum BUSY cycles without memReady; 0 disables timeout.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 m0Read, m0Write  in  1 each  core (master 0) request strobes, held until m0Ready or m0Error.
REQ-008 m0Addr  in  ADDR_W  core address.  m0DataOut  in  DATA_W  core write data.
REQ-009 m0DataIn  out  DATA_W  read data.  m0Ready  out  1  transfer done.  m0Error  out  1  timeout pulse.
REQ-010 m1Read, m1Write, m1Addr, m1DataOut, m1DataIn, m1Ready, m1Error: same as m0*, for master 1 (DMA/debug).
REQ-011 memRead, memWrite  out  1 each  strobes to mem_controller.  memAddr  out  ADDR_W.  memDataOut  out  DATA_W.
REQ-012 memDataIn  in  DATA_W  read data.  memReady  in  1  memory transfer complete.
REQ-013 grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when not BUSY.

Function
REQ-014 States SHALL be IDLE, BUSY, RELEASE; owner and rrPtr are registers.
REQ-015 IDLE: a master requests when Read|Write is high; single requester -> owner = it, go BUSY next edge.
REQ-016 IDLE, both requesting: owner = master selected by rrPtr; rrPtr then points to the other master.
REQ-017 Single-requester grant SHALL also set rrPtr to the non-granted master.
REQ-018 BUSY: memRead/memWrite/memAddr/memDataOut SHALL be combinational copies of owner's signals; non-owner sees none of them.
REQ-019 If owner asserts Read and Write together, only memWrite SHALL be driven.
REQ-020 memDataIn SHALL be broadcast to m0DataIn and m1DataIn at all times.
REQ-021 mXReady = memReady & BUSY & owner==X (combinational); non-owner Ready SHALL be 0.
REQ-022 BUSY with memReady high -> RELEASE next edge.
REQ-023 RELEASE lasts exactly one cycle with all mem strobes, Ready, and grant at 0, then IDLE.
REQ-024 Request still high in IDLE after RELEASE SHALL be arbitrated as a new transfer.
REQ-025 Timeout counter clears on entry to BUSY and increments each BUSY cycle without memReady.
REQ-026 Counter reaching TIMEOUT SHALL pulse owner's Error for one cycle and go RELEASE; no Ready is issued.
REQ-027 memReady in the same cycle as timeout expiry SHALL win: Ready issued, Error not issued.
REQ-028 Owner dropping both strobes in BUSY (abort) SHALL go RELEASE next edge, with no Ready or Error.
REQ-029 Grant latency: request seen in IDLE at edge N -> mem strobes high during cycle N+1.
REQ-030 Minimum back-to-back spacing: one RELEASE cycle plus one IDLE cycle between transfers.

Reset
REQ-031 rst low SHALL immediately force state IDLE, owner 0, rrPtr 0 (core first), and counter 0.
REQ-032 During reset, memRead, memWrite, all Ready/Error outputs, and grant SHALL be 0.
REQ-033 Reset asserted mid-BUSY SHALL drop mem strobes asynchronously.
REQ-034 After reset release, the first arbitration SHALL occur at the first rising edge.

Structure
REQ-035 Shared package aftab_arb_pkg SHALL hold the state enum, owner encodings (OWNER_M0/OWNER_M1), and default TIMEOUT.
REQ-036 One sub-module, aftab_arb_timeout_counter, SHALL implement the clearable saturating counter with expiry flag.
REQ-037 All other logic (FSM, round-robin, muxing) SHALL reside in aftab_mem_arbiter.

Verification
REQ-038 Core-only read at 0x0000_0800 with memReady 3 cycles after memRead -> m0Ready in that cycle, m0DataIn = memDataIn, then RELEASE then IDLE, grant 01 only during BUSY.
REQ-039 Both masters request in the same cycle after reset -> m0 served first, m1 next; repeat both -> m0 served again; strict alternation over 8 transfers.
REQ-040 m1 write 0xFF to 0x804 while m0 idle -> memWrite=1, memAddr=0x804, memDataOut=0xFF; m0Ready stays 0.
REQ-041 TIMEOUT=4 with memReady never asserted -> m0Error one-cycle pulse after 4 BUSY cycles, no m0Ready; memReady on the expiry cycle -> m0Ready, no m0Error.
REQ-042 rst low mid-BUSY -> memRead/memWrite low without a clock edge; after release, pending m1 request is granted only after any simultaneous m0 request (rrPtr=0).
REQ-043 Owner aborts in BUSY -> no Ready or Error; the other pending master is granted after RELEASE and IDLE.
